// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the two-port RAM arbiter.
// The arbiter takes the slave view; the requester/RAM environment takes the master view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] bus_RAM_ADDRESS;
  logic [DATA_W-1:0] bus_RAM_DATA_IN;
  logic [DATA_W-1:0] bus_RAM_DATA_OUT;
  logic              wire_RW;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_RAM_DATA_OUT,
    output ack0, ack1, rdata0, rdata1, bus_RAM_ADDRESS, bus_RAM_DATA_IN,
           wire_RW, busy, grant_id
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_RAM_DATA_OUT,
    input  ack0, ack1, rdata0, rdata1, bus_RAM_ADDRESS, bus_RAM_DATA_IN,
           wire_RW, busy, grant_id
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: one transaction at a time,
// round-robin or fixed-priority grant, all outputs registered.
module ram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RAM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic          wire_clock_50Mhz,
  input  logic          wire_reset,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam int         LAT_W    = 2;

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_grant_id;
  logic              r_rw;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ram_we;
  logic              r_busy;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any_req;
  logic              w_winner;
  logic              w_sel_rw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any_req = bus.req0 | bus.req1;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_winner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end else if (bus.req1) begin
      w_winner = 1'b1;
    end
  end

  assign w_sel_rw    = w_winner ? bus.rw1    : bus.rw0;
  assign w_sel_addr  = w_winner ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wire_clock_50Mhz) begin
    if (wire_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_rw         <= 1'b0;
      r_lat_cnt    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ram_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_id <= w_winner;
            r_rw       <= w_sel_rw;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_ram_we   <= w_sel_rw;
            r_lat_cnt  <= LAT_W'(RAM_LATENCY - 1);
            r_busy     <= 1'b1;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_rw) begin
            r_state <= S_RESP;
          end else if (r_lat_cnt == '0) begin
            if (r_grant_id) r_rdata1 <= bus.bus_RAM_DATA_OUT;
            else            r_rdata0 <= bus.bus_RAM_DATA_OUT;
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (r_grant_id) r_ack1 <= 1'b1;
          else            r_ack0 <= 1'b1;
          r_last_grant <= r_grant_id;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0            = r_ack0;
  assign bus.ack1            = r_ack1;
  assign bus.rdata0          = r_rdata0;
  assign bus.rdata1          = r_rdata1;
  assign bus.bus_RAM_ADDRESS = r_addr;
  assign bus.bus_RAM_DATA_IN = r_wdata;
  assign bus.wire_RW         = r_ram_we;
  assign bus.busy            = r_busy;
  assign bus.grant_id        = r_grant_id;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: DUT A is round-robin with RAM_LATENCY=1, DUT B is fixed-priority with RAM_LATENCY=3.
module tb_ram_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;
  int   we_cnt_a;
  int   both_a;
  int   both_b;

  ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .wire_clock_50Mhz (clk),
    .wire_reset       (rst_a),
    .bus              (ifa)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(3), .FIXED_PRIO(1)) dut_b (
    .wire_clock_50Mhz (clk),
    .wire_reset       (rst_b),
    .bus              (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: A reads combinationally, B has two output register stages
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] rd_b1;
  logic [15:0] rd_b2;

  always @(posedge clk) begin
    if (ifa.wire_RW) mem_a[ifa.bus_RAM_ADDRESS[7:0]] <= ifa.bus_RAM_DATA_IN;
    if (ifb.wire_RW) mem_b[ifb.bus_RAM_ADDRESS[7:0]] <= ifb.bus_RAM_DATA_IN;
    rd_b1 <= mem_b[ifb.bus_RAM_ADDRESS[7:0]];
    rd_b2 <= rd_b1;
  end
  assign ifa.bus_RAM_DATA_OUT = mem_a[ifa.bus_RAM_ADDRESS[7:0]];
  assign ifb.bus_RAM_DATA_OUT = rd_b2;

  always @(negedge clk) begin
    if (ifa.wire_RW) we_cnt_a++;
    if (ifa.ack0 && ifa.ack1) both_a++;
    if (ifb.ack0 && ifb.ack1) both_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit dut, input bit port, input bit rw,
                       input logic [15:0] a, input logic [15:0] d);
    if (!dut) begin
      if (!port) begin ifa.req0 = 1'b1; ifa.rw0 = rw; ifa.addr0 = a; ifa.wdata0 = d; end
      else       begin ifa.req1 = 1'b1; ifa.rw1 = rw; ifa.addr1 = a; ifa.wdata1 = d; end
    end else begin
      if (!port) begin ifb.req0 = 1'b1; ifb.rw0 = rw; ifb.addr0 = a; ifb.wdata0 = d; end
      else       begin ifb.req1 = 1'b1; ifb.rw1 = rw; ifb.addr1 = a; ifb.wdata1 = d; end
    end
  endtask

  task automatic drop(input bit dut, input bit port);
    if (!dut) begin
      if (!port) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
    end else begin
      if (!port) ifb.req0 = 1'b0; else ifb.req1 = 1'b0;
    end
  endtask

  // Ticks until an ack appears (bounded); n = ticks taken, port = which ack
  task automatic wait_ack(input bit dut, output bit port, output int n);
    bit a0;
    bit a1;
    n  = 0;
    a0 = 1'b0;
    a1 = 1'b0;
    do begin
      tick();
      n++;
      a0 = dut ? ifb.ack0 : ifa.ack0;
      a1 = dut ? ifb.ack1 : ifa.ack1;
    end while (!(a0 || a1) && n < 40);
    port = a1;
    check("ack_seen", {31'b0, a0 | a1}, 32'd1);
  endtask

  bit p;
  int n;
  int we0;

  initial begin
    total = 0; bad = 0; we_cnt_a = 0; both_a = 0; both_b = 0;
    ifa.req0 = 0; ifa.req1 = 0; ifa.rw0 = 0; ifa.rw1 = 0;
    ifa.addr0 = 0; ifa.addr1 = 0; ifa.wdata0 = 0; ifa.wdata1 = 0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.rw0 = 0; ifb.rw1 = 0;
    ifb.addr0 = 0; ifb.addr1 = 0; ifb.wdata0 = 0; ifb.wdata1 = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;

    check("rst_ctl_a", {ifa.ack0, ifa.ack1, ifa.busy, ifa.grant_id, ifa.wire_RW}, 0);
    check("rst_bus_a", {ifa.bus_RAM_ADDRESS, ifa.bus_RAM_DATA_IN}, 0);
    check("rst_rdata_a", {ifa.rdata0, ifa.rdata1}, 0);
    check("rst_ctl_b", {ifb.ack0, ifb.ack1, ifb.busy, ifb.grant_id, ifb.wire_RW}, 0);

    // Port 0 write then read-back of 0x0010
    we0 = we_cnt_a;
    issue(0, 0, 1, 16'h0010, 16'hBEEF);
    tick();
    check("wr_first_access", {ifa.busy, ifa.wire_RW, ifa.grant_id}, 3'b110);
    check("wr_bus", {ifa.bus_RAM_ADDRESS, ifa.bus_RAM_DATA_IN}, 32'h0010_BEEF);
    wait_ack(0, p, n);
    check("wr_lat", n, 2);
    check("wr_port", {31'b0, p}, 0);
    drop(0, 0);
    check("wr_we_cycles", we_cnt_a - we0, 1);
    check("wr_mem", {16'b0, mem_a[16]}, 32'h0000_BEEF);

    issue(0, 0, 0, 16'h0010, 16'h0000);
    wait_ack(0, p, n);
    check("rd_lat", n, 3);
    check("rd_port", {31'b0, p}, 0);
    check("rd_data", {16'b0, ifa.rdata0}, 32'h0000_BEEF);
    drop(0, 0);
    check("rd_no_write", we_cnt_a - we0, 1);

    // Round-robin after reset: both held, expect 0,1,0,1 at 3-cycle spacing
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    issue(0, 0, 0, 16'h0010, 16'h0000);
    issue(0, 1, 0, 16'h0010, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, p, n);
      check("rr_order", {31'b0, p}, k % 2);
      check("rr_spacing", n, 3);
    end
    drop(0, 0); drop(0, 1);
    check("rr_rdata1", {16'b0, ifa.rdata1}, 32'h0000_BEEF);
    check("rr_no_dual_ack", both_a, 0);

    // Address change after grant is ignored; address held in IDLE
    issue(0, 0, 0, 16'h0001, 16'h0000);
    tick();
    check("hold_grant", {16'b0, ifa.bus_RAM_ADDRESS}, 32'h0001);
    ifa.addr0 = 16'h0002;
    tick();
    check("hold_access", {16'b0, ifa.bus_RAM_ADDRESS}, 32'h0001);
    tick();
    check("hold_ack", {15'b0, ifa.ack0, ifa.bus_RAM_ADDRESS}, 32'h1_0001);
    drop(0, 0);
    tick();
    check("hold_idle", {15'b0, ifa.busy, ifa.bus_RAM_ADDRESS}, 32'h0_0001);

    // Reset during ACCESS of a port 1 read drops it without ack
    issue(0, 1, 0, 16'h0010, 16'h0000);
    tick();
    check("mid_grant", {ifa.busy, ifa.grant_id}, 2'b11);
    rst_a = 1'b1;
    drop(0, 1);
    tick();
    rst_a = 1'b0;
    check("mid_rst_ctl", {ifa.ack0, ifa.ack1, ifa.busy, ifa.grant_id, ifa.wire_RW}, 0);
    check("mid_rst_bus", {ifa.bus_RAM_ADDRESS, ifa.bus_RAM_DATA_IN}, 0);
    check("mid_rst_rdata", {ifa.rdata0, ifa.rdata1}, 0);
    tick();
    check("mid_no_ack", {ifa.ack0, ifa.ack1, ifa.busy}, 0);
    issue(0, 0, 0, 16'h0010, 16'h0000);
    wait_ack(0, p, n);
    check("post_rst_lat", n, 3);
    check("post_rst_port", {31'b0, p}, 0);
    check("post_rst_data", {16'b0, ifa.rdata0}, 32'h0000_BEEF);
    drop(0, 0);

    // DUT B: RAM_LATENCY=3
    issue(1, 0, 1, 16'h0010, 16'h5A5A);
    wait_ack(1, p, n);
    check("b_wr_lat", n, 3);
    drop(1, 0);
    issue(1, 0, 0, 16'h0010, 16'h0000);
    wait_ack(1, p, n);
    check("b_rd0_lat", n, 5);
    check("b_rd0_data", {16'b0, ifb.rdata0}, 32'h0000_5A5A);
    drop(1, 0);
    issue(1, 0, 1, 16'h00FF, 16'h1234);
    wait_ack(1, p, n);
    check("b_wr2_lat", n, 3);
    drop(1, 0);
    issue(1, 1, 0, 16'h00FF, 16'h0000);
    wait_ack(1, p, n);
    check("b_rd1_lat", n, 5);
    check("b_rd1_port", {31'b0, p}, 1);
    check("b_rd1_data", {ifb.rdata1, ifb.rdata0}, 32'h1234_5A5A);
    drop(1, 1);

    // Fixed priority: port 0 wins every conflict
    issue(1, 0, 0, 16'h0010, 16'h0000);
    issue(1, 1, 0, 16'h00FF, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      wait_ack(1, p, n);
      check("fp_port0", {31'b0, p}, 0);
      check("fp_spacing", n, 5);
    end
    drop(1, 0);
    tick();
    check("fp_p1_grant", {ifb.busy, ifb.grant_id}, 2'b11);
    wait_ack(1, p, n);
    check("fp_p1_port", {31'b0, p}, 1);
    check("fp_p1_lat", n, 4);
    drop(1, 1);
    check("fp_no_dual_ack", both_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
